riscv_decode_stage: RTL and testbench

Registered instruction-decode stage for the RV32I core. It sits between fetch and the ALU/execute stage. It accepts a 32-bit instruction word and its PC over a valid/ready handshake. It produces the one-hot operation flags the ALU consumes, plus register indices, the sign-extended immediate and an illegal-instruction indication, all over a second valid/ready handshake with one cycle of latency.

---
 rtl/riscv_dec_pkg.sv | 37 +++
 rtl/riscv_dec_comb.sv | 125 ++++++++++++
 rtl/riscv_decode_stage.sv | 104 ++++++++++
 tb/tb_riscv_decode_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dec_pkg.sv
// rtl/riscv_dec_pkg.sv - RV32I decode constants, op-vector bit indices and bundle type
package riscv_dec_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int OP_W = 38;
    localparam logic [5:0] OP_BEQ  = 6'd0,  OP_BNE  = 6'd1,  OP_BLT  = 6'd2,  OP_BGE   = 6'd3;
    localparam logic [5:0] OP_BLTU = 6'd4,  OP_BGEU = 6'd5,  OP_ADD  = 6'd6,  OP_SUB   = 6'd7;
    localparam logic [5:0] OP_SLL  = 6'd8,  OP_SLT  = 6'd9,  OP_SLTU = 6'd10, OP_XOR   = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12, OP_SRA  = 6'd13, OP_OR   = 6'd14, OP_AND   = 6'd15;
    localparam logic [5:0] OP_ADDI = 6'd16, OP_SLTI = 6'd17, OP_SLTIU = 6'd18, OP_XORI = 6'd19;
    localparam logic [5:0] OP_ORI  = 6'd20, OP_ANDI = 6'd21, OP_SLLI = 6'd22, OP_SRLI  = 6'd23;
    localparam logic [5:0] OP_SRAI = 6'd24, OP_LUI  = 6'd25, OP_AUIPC = 6'd26, OP_JAL  = 6'd27;
    localparam logic [5:0] OP_JALR = 6'd28, OP_LB   = 6'd29, OP_LH   = 6'd30, OP_LW    = 6'd31;
    localparam logic [5:0] OP_LBU  = 6'd32, OP_LHU  = 6'd33, OP_SB   = 6'd34, OP_SH    = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd36, OP_ECALL = 6'd37;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic            illegal;
        logic [31:0]     pc;
    } bundle_t;
endpackage

// File: rtl/riscv_dec_comb.sv
// rtl/riscv_dec_comb.sv - combinational RV32I decoder: instruction word to op vector, fields, immediate
module riscv_dec_comb
    import riscv_dec_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [OP_W-1:0] op,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     imm,
    output logic            illegal
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] sel;
    logic       legal, use_rs1, use_rs2, use_rd, shamt;
    imm_fmt_e   fmt;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        legal = 1'b0; sel = '0; fmt = IMM_NONE; shamt = 1'b0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
        case (opc)
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; legal = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: sel = OP_ADD;
                    {7'h20, 3'd0}: sel = OP_SUB;
                    {7'h00, 3'd1}: sel = OP_SLL;
                    {7'h00, 3'd2}: sel = OP_SLT;
                    {7'h00, 3'd3}: sel = OP_SLTU;
                    {7'h00, 3'd4}: sel = OP_XOR;
                    {7'h00, 3'd5}: sel = OP_SRL;
                    {7'h20, 3'd5}: sel = OP_SRA;
                    {7'h00, 3'd6}: sel = OP_OR;
                    {7'h00, 3'd7}: sel = OP_AND;
                    default:       legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = IMM_I; legal = 1'b1;
                case (f3)
                    3'd0: sel = OP_ADDI;
                    3'd2: sel = OP_SLTI;
                    3'd3: sel = OP_SLTIU;
                    3'd4: sel = OP_XORI;
                    3'd6: sel = OP_ORI;
                    3'd7: sel = OP_ANDI;
                    3'd1: begin sel = OP_SLLI; shamt = 1'b1; legal = (f7 == 7'h00); end
                    default: begin
                        shamt = 1'b1;
                        sel   = (f7 == 7'h20) ? OP_SRAI : OP_SRLI;
                        legal = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                endcase
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = IMM_I; legal = 1'b1;
                case (f3)
                    3'd0: sel = OP_LB;
                    3'd1: sel = OP_LH;
                    3'd2: sel = OP_LW;
                    3'd4: sel = OP_LBU;
                    3'd5: sel = OP_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S; legal = 1'b1;
                case (f3)
                    3'd0: sel = OP_SB;
                    3'd1: sel = OP_SH;
                    3'd2: sel = OP_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B; legal = 1'b1;
                case (f3)
                    3'd0: sel = OP_BEQ;
                    3'd1: sel = OP_BNE;
                    3'd4: sel = OP_BLT;
                    3'd5: sel = OP_BGE;
                    3'd6: sel = OP_BLTU;
                    3'd7: sel = OP_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI:   begin use_rd = 1'b1; fmt = IMM_U; sel = OP_LUI;   legal = 1'b1; end
            OPC_AUIPC: begin use_rd = 1'b1; fmt = IMM_U; sel = OP_AUIPC; legal = 1'b1; end
            OPC_JAL:   begin use_rd = 1'b1; fmt = IMM_J; sel = OP_JAL;   legal = 1'b1; end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = IMM_I; sel = OP_JALR;
                legal = (f3 == 3'd0);
            end
            OPC_SYSTEM: begin sel = OP_ECALL; legal = (instr == 32'h0000_0073); end
            default: legal = 1'b0;
        endcase
    end

    // Illegal words leave every field zero so execute never sees stale register indices.
    always_comb begin
        op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
        illegal = !legal;
        if (legal) begin
            op[sel] = 1'b1;
            rs1 = use_rs1 ? instr[19:15] : 5'd0;
            rs2 = use_rs2 ? instr[24:20] : 5'd0;
            rd  = use_rd  ? instr[11:7]  : 5'd0;
            case (fmt)
                IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
                IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                IMM_U: imm = {instr[31:12], 12'b0};
                IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                default: imm = '0;
            endcase
            if (shamt) imm = {27'b0, instr[24:20]};
        end
    end
endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - registered RV32I decode stage with valid/ready handshakes
// Optional RV_DECODE_SKID_EN adds a skid register so in_ready comes straight from a flop.
module riscv_decode_stage
    import riscv_dec_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic            out_is_jump,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_imm,
    output logic [31:0]     out_pc,
    output logic            out_illegal
);
    logic [OP_W-1:0] d_op;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [31:0]     d_imm;
    logic            d_illegal;
    bundle_t         dec, out_q;
    logic            out_v, push;

    riscv_dec_comb u_dec (
        .instr   (in_instr),
        .op      (d_op),
        .rs1     (d_rs1),
        .rs2     (d_rs2),
        .rd      (d_rd),
        .imm     (d_imm),
        .illegal (d_illegal)
    );

    assign dec  = '{op: d_op, rs1: d_rs1, rs2: d_rs2, rd: d_rd, imm: d_imm, illegal: d_illegal, pc: in_pc};
    assign push = in_valid && in_ready;

`ifdef RV_DECODE_SKID_EN
    bundle_t skid_q;
    logic    skid_v, load;

    assign in_ready = !skid_v;
    assign load     = out_ready || !out_v;

    // The skid entry always drains before a new input, which keeps bundle order intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v  <= 1'b0;
            out_q  <= '0;
            skid_v <= 1'b0;
            skid_q <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (load) begin
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (push) begin
                out_q <= dec;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (push) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end
`else
    assign in_ready = !out_v || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            out_q <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
        end else if (push) begin
            out_q <= dec;
            out_v <= 1'b1;
        end else if (out_ready) begin
            out_v <= 1'b0;
        end
    end
`endif

    assign out_valid   = out_v;
    assign out_op      = out_q.op;
    assign out_is_jump = out_q.op[OP_JAL] | out_q.op[OP_JALR];
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imm     = out_q.imm;
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - scoreboard bench for riscv_decode_stage with directed vectors
module tb_riscv_decode_stage;
    import riscv_dec_pkg::*;

    logic            clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic            in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0]     in_instr = '0, in_pc = '0;
    logic            in_ready, out_valid, out_is_jump, out_illegal;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [31:0]     out_imm, out_pc;

    riscv_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_is_jump(out_is_jump),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [4:0]      rs1, rs2, rd;
        logic [31:0]     imm;
        logic            illegal, jump;
        logic [31:0]     pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] idx, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        e.op = '0;
        e.op[idx] = 1'b1;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.pc = pc;
        e.illegal = 1'b0;
        e.jump = (idx == OP_JAL) || (idx == OP_JALR);
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] pc);
        exp_t e;
        e.op = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0;
        e.illegal = 1'b1; e.jump = 1'b0; e.pc = pc;
        return e;
    endfunction

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        int n = 0;
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for pc 0x%0h", pc);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    logic            hold_v = 1'b0;
    logic [OP_W-1:0] snap_op;
    logic [31:0]     snap_imm, snap_pc;
    logic [4:0]      snap_rd;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_op", 64'(out_op), 64'(snap_op));
                check("hold_imm", 64'(out_imm), 64'(snap_imm));
                check("hold_pc", 64'(out_pc), 64'(snap_pc));
                check("hold_rd", 64'(out_rd), 64'(snap_rd));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_bundle: pc 0x%0h with empty scoreboard", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("op", 64'(out_op), 64'(e.op));
                    check("rs1", 64'(out_rs1), 64'(e.rs1));
                    check("rs2", 64'(out_rs2), 64'(e.rs2));
                    check("rd", 64'(out_rd), 64'(e.rd));
                    check("imm", 64'(out_imm), 64'(e.imm));
                    check("pc", 64'(out_pc), 64'(e.pc));
                    check("illegal", 64'(out_illegal), 64'(e.illegal));
                    check("is_jump", 64'(out_is_jump), 64'(e.jump));
                    check("onehot", 64'($countones(out_op)), e.illegal ? 64'd0 : 64'd1);
                end
            end
            hold_v   = out_valid && !out_ready && !flush;
            snap_op  = out_op;
            snap_imm = out_imm;
            snap_pc  = out_pc;
            snap_rd  = out_rd;
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_op"}, 64'(out_op), 64'd0);
        check({tag, "_is_jump"}, 64'(out_is_jump), 64'd0);
        check({tag, "_illegal"}, 64'(out_illegal), 64'd0);
        check({tag, "_regs"}, 64'({out_rs1, out_rs2, out_rd}), 64'd0);
        check({tag, "_imm"}, 64'(out_imm), 64'd0);
        check({tag, "_pc"}, 64'(out_pc), 64'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outs("reset");

        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h0050_0093, 32'h100, mk(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 32'h100));
        send(32'hFE20_8EE3, 32'h104, mk(OP_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'h104));

        fork
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(32'h0020_81B3, 32'h108, mk(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h108));
                send(32'h4030_D093, 32'h10C, mk(OP_SRAI, 5'd1, 5'd0, 5'd1, 32'd3, 32'h10C));
                send(32'h1234_52B7, 32'h110, mk(OP_LUI, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h110));
            end
        join

        send(32'hFFFF_FFFF, 32'h114, mk_ill(32'h114));
        send(32'h0000_0073, 32'h118, mk(OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd0, 32'h118));
        send(32'h0080_00EF, 32'h11C, mk(OP_JAL, 5'd0, 5'd0, 5'd1, 32'd8, 32'h11C));
        send(32'h0020_A623, 32'h120, mk(OP_SW, 5'd1, 5'd2, 5'd0, 32'd12, 32'h120));
        send(32'hFFF1_2183, 32'h124, mk(OP_LW, 5'd2, 5'd0, 5'd3, 32'hFFFF_FFFF, 32'h124));
        send(32'h0200_9093, 32'h128, mk_ill(32'h128));
        drain("stream");

        // Flush with output stalled (and skid occupied when present) plus a new input offered.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h0010_0093, 32'h200, mk(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'd1, 32'h200));
`ifdef RV_DECODE_SKID_EN
        send(32'h0020_0093, 32'h204, mk(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'd2, 32'h204));
`endif
        in_valid = 1'b1; in_instr = 32'h0030_0093; in_pc = 32'h208; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("flush_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a cycle while a bundle is held.
        out_ready = 1'b0;
        send(32'h0080_00EF, 32'h300, mk(OP_JAL, 5'd0, 5'd0, 5'd1, 32'd8, 32'h300));
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        sb.delete();
        #1 check_reset_outs("async_rst");
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        send(32'h0020_81B3, 32'h400, mk(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h400));
        drain("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
